// File: rtl/y_mul_seq.sv
// Sequential shift-add multiplier: W iterations produce a 2W-bit product behind a start/busy/done handshake.
// Define Y_MUL_SIGNED_EN to use two's-complement operands (magnitudes multiplied, sign applied on DONE entry).
module y_mul_seq #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = $clog2(W) + 1;

   // Handshake: start is sampled only in IDLE/DONE; busy mirrors RUN; done is high for the single DONE cycle.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  mcand, hi, lo;
   logic          c;
   logic [CW-1:0] cnt;
   logic          accept, last;
   logic [W:0]    sum;
   logic [2*W:0]  shifted;
   logic [W-1:0]  op_a, op_b;

`ifdef Y_MUL_SIGNED_EN
   logic           neg;
   logic [2*W-1:0] prod_neg;

   // Magnitude of the most-negative value wraps to 2^(W-1), which is correct as an unsigned operand.
   assign op_a     = a[W-1] ? (~a + 1'b1) : a;
   assign op_b     = b[W-1] ? (~b + 1'b1) : b;
   assign prod_neg = ~shifted[2*W-1:0] + 1'b1;
`else
   assign op_a = a;
   assign op_b = b;
`endif

   assign last    = (cnt == CW'(W - 1));
   assign sum     = {c, hi} + (lo[0] ? {1'b0, mcand} : '0);
   assign shifted = {sum, lo} >> 1;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            accept    = start;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
`ifdef Y_MUL_SIGNED_EN
         neg   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            mcand <= op_a;
            lo    <= op_b;
            hi    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
`ifdef Y_MUL_SIGNED_EN
            neg   <= a[W-1] ^ b[W-1];
`endif
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
`ifdef Y_MUL_SIGNED_EN
            // The final iteration also applies the sign, so latency matches the unsigned build.
            if (last && neg) begin
               c        <= 1'b0;
               {hi, lo} <= prod_neg;
            end else begin
               {c, hi, lo} <= shifted;
            end
`else
            {c, hi, lo} <= shifted;
`endif
         end
      end
   end

   assign busy    = (state == RUN);
   assign done    = (state == DONE);
   assign product = {hi, lo};

endmodule

// File: tb/tb_y_mul_seq.sv
// Directed-vector bench for y_mul_seq (W=32): latency, busy window, product values, ignored start,
// back-to-back start and mid-operation reset. Signed vectors replace the extremes under Y_MUL_SIGNED_EN.
module tb_y_mul_seq;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           busy, done;
   logic [2*W-1:0] product;

   int n_vec = 0;
   int n_err = 0;

   y_mul_seq #(.W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // Called at a negedge; drives the operands and start for one accepting edge.
   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the negedge right after the accepting edge; returns at the negedge where done is seen.
   // poke >= 0 pulses start with a=b=9 for one cycle at that point in RUN.
   task automatic wait_done(input string tag, input logic [63:0] exp, input int poke);
      int lat = 0;
      int busy_cnt = 0;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         start = (lat == poke);
         if (lat == poke) begin
            a = 9;
            b = 9;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({tag, "_latency"}, 64'(lat), 64'(W));
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
      check({tag, "_product"}, product, exp);
   endtask

   task automatic after_done(input string tag, input logic [63:0] exp);
      @(negedge clk);
      check({tag, "_done_drop"}, 64'(done), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
      check({tag, "_hold"}, product, exp);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [63:0] exp);
      @(negedge clk);
      launch(av, bv);
      check({tag, "_busy_e0"}, 64'(busy), 64'd1);
      wait_done(tag, exp, -1);
      after_done(tag, exp);
   endtask

   initial begin
      int done_seen;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_product", product, 64'd0);

      run_op("basic_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
`ifdef Y_MUL_SIGNED_EN
      run_op("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      run_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op("s_0xm1", 32'd0, 32'hFFFF_FFFF, 64'd0);
      run_op("s_7xm6", 32'd7, 32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6);
`else
      run_op("max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_op("zero_x_max", 32'd0, 32'hFFFF_FFFF, 64'd0);
      run_op("msb_x_msb", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op("mixed", 32'h1234_5678, 32'h0000_1000, 64'h0000_0123_4567_8000);
`endif

      // start pulsed mid-RUN with new operands must be ignored
      @(negedge clk);
      launch(32'd7, 32'd6);
      wait_done("ignored_start", 64'd42, 5);
      after_done("ignored_start", 64'd42);

      // back-to-back: start held through the DONE cycle
      @(negedge clk);
      launch(32'd3, 32'd5);
      wait_done("b2b_first", 64'd15, -1);
      launch(32'd2, 32'd10);
      check("b2b_done_drop", 64'(done), 64'd0);
      check("b2b_busy", 64'(busy), 64'd1);
      wait_done("b2b_second", 64'd20, -1);
      after_done("b2b_second", 64'd20);

      // reset at iteration 10 aborts without a done pulse
      @(negedge clk);
      launch(32'd123, 32'd456);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_product", product, 64'd0);
      done_seen = 0;
      repeat (2 * W) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("abort_no_done", 64'(done_seen), 64'd0);

      // machine still works after the abort
      run_op("post_abort", 32'd1000, 32'd1000, 64'd1000000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
